// File: rtl/semaforo_pkg.sv
// Shared types and constants for the two-road phase scheduler.
// Light colours are one-hot so each lamp bit drives a lamp directly.
package semaforo_pkg;

  localparam int DUR_W = 8;

  typedef enum logic [2:0] {
    A_VERDE,
    A_AMARELO,
    VERM_A,
    PED_A,
    B_VERDE,
    B_AMARELO,
    VERM_B,
    PED_B
  } state_t;

  localparam logic [2:0] VERDE    = 3'b001;
  localparam logic [2:0] AMARELO  = 3'b010;
  localparam logic [2:0] VERMELHO = 3'b100;

  function automatic logic is_ped(input state_t s);
    return (s == PED_A) || (s == PED_B);
  endfunction

endpackage

// File: rtl/semaforo_arbitro_if.sv
// Button inputs and lamp/grant outputs of the scheduler.
// The slave side is the scheduler; the master side drives the buttons.
interface semaforo_arbitro_if #(
  parameter int N_BT = 4
);

  logic [N_BT-1:0] bt;
  logic [2:0]      A;
  logic [2:0]      B;
  logic [N_BT-1:0] P;
  logic [N_BT-1:0] pend;

  modport master (
    output bt,
    input  A,
    input  B,
    input  P,
    input  pend
  );

  modport slave (
    input  bt,
    output A,
    output B,
    output P,
    output pend
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request after ptr, wrapping.
// Purely combinational; gnt is zero and gnt_idx echoes ptr when idle.
module rr_arbiter #(
  parameter  int N_BT = 4,
  localparam int IW   = $clog2(N_BT)
) (
  input  logic [N_BT-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [N_BT-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic          w_hit;
  logic [IW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    w_hit   = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N_BT; k++) begin
      w_idx = IW'((int'(ptr) + k) % N_BT);
      if (!w_hit && req[w_idx]) begin
        w_hit        = 1'b1;
        gnt_idx      = w_idx;
        gnt[w_idx]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/semaforo_arbitro.sv
// Two-road light sequencer with round-robin pedestrian walk phases.
// Lamps and walk grant are decoded from the state register only.
module semaforo_arbitro
  import semaforo_pkg::*;
#(
  parameter logic [DUR_W-1:0] T_VERDE    = 8'd8,
  parameter logic [DUR_W-1:0] T_AMARELO  = 8'd3,
  parameter logic [DUR_W-1:0] T_VERMELHO = 8'd2,
  parameter logic [DUR_W-1:0] T_PEDESTRE = 8'd6,
  parameter int               N_BT       = 4
) (
  input logic               clk,
  input logic               rst,
  semaforo_arbitro_if.slave bus
);

  localparam int IW = $clog2(N_BT);

  state_t           r_state;
  state_t           w_nstate;
  logic [DUR_W-1:0] r_cnt;
  logic [DUR_W-1:0] w_ncnt;
  logic [N_BT-1:0]  r_pend;
  logic [IW-1:0]    r_ptr;
  logic [N_BT-1:0]  w_gnt;
  logic [IW-1:0]    w_gnt_idx;
  logic [N_BT-1:0]  w_ped_mask;
  logic [N_BT-1:0]  w_set;
  logic [N_BT-1:0]  w_clr;
  logic             w_ped;
  logic             w_grant_now;

  function automatic logic [DUR_W-1:0] load(
    input state_t s
  );
    logic [DUR_W-1:0] v;
    case (s)
      A_VERDE, B_VERDE:     v = T_VERDE - 8'd1;
      A_AMARELO, B_AMARELO: v = T_AMARELO - 8'd1;
      VERM_A, VERM_B:       v = T_VERMELHO - 8'd1;
      default:              v = T_PEDESTRE - 8'd1;
    endcase
    return v;
  endfunction

  rr_arbiter #(
    .N_BT(N_BT)
  ) u_rr (
    .req    (r_pend),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_idx(w_gnt_idx)
  );

  // In a walk phase ptr already names the crosswalk being served
  assign w_ped_mask = N_BT'(1) << r_ptr;
  assign w_ped      = is_ped(r_state);

  always_comb begin
    w_nstate    = r_state;
    w_ncnt      = r_cnt - 8'd1;
    w_grant_now = 1'b0;
    if (r_cnt == '0) begin
      unique case (r_state)
        A_VERDE:   w_nstate = A_AMARELO;
        A_AMARELO: w_nstate = VERM_A;
        VERM_A: begin
          w_grant_now = |r_pend;
          w_nstate    = w_grant_now ? PED_A : B_VERDE;
        end
        PED_A:     w_nstate = B_VERDE;
        B_VERDE:   w_nstate = B_AMARELO;
        B_AMARELO: w_nstate = VERM_B;
        VERM_B: begin
          w_grant_now = |r_pend;
          w_nstate    = w_grant_now ? PED_B : A_VERDE;
        end
        PED_B:     w_nstate = A_VERDE;
        default:   w_nstate = A_VERDE;
      endcase
      w_ncnt = load(w_nstate);
    end
  end

  assign w_set = bus.bt & ~(w_ped ? w_ped_mask : '0);
  assign w_clr = w_grant_now ? w_gnt : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= A_VERDE;
      r_cnt   <= T_VERDE - 8'd1;
      r_pend  <= '0;
      r_ptr   <= IW'(N_BT - 1);
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_pend  <= (r_pend | w_set) & ~w_clr;
      if (w_grant_now) begin
        r_ptr <= w_gnt_idx;
      end
    end
  end

  always_comb begin
    bus.A = VERMELHO;
    bus.B = VERMELHO;
    bus.P = '0;
    unique case (r_state)
      A_VERDE:      bus.A = VERDE;
      A_AMARELO:    bus.A = AMARELO;
      B_VERDE:      bus.B = VERDE;
      B_AMARELO:    bus.B = AMARELO;
      PED_A, PED_B: bus.P = w_ped_mask;
      default:      bus.P = '0;
    endcase
  end

  assign bus.pend = r_pend;

endmodule

// File: tb/tb_semaforo_arbitro.sv
// Bench for semaforo_arbitro: default timing and 1-cycle green/yellow,
// random presses checked against a phase-list reference model.
module tb_semaforo_arbitro;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  semaforo_arbitro_if #(.N_BT(4)) bus0 ();
  semaforo_arbitro_if #(.N_BT(4)) bus1 ();

  semaforo_arbitro #(
    .N_BT(4)
  ) u_dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  semaforo_arbitro #(
    .T_VERDE  (8'd1),
    .T_AMARELO(8'd1),
    .N_BT     (4)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase list: 0 A green,1 A yellow,2 gap,3 walk,4 B green,5 B yellow,6 gap,7 walk
  int        ph   [2];
  int        left [2];
  int        mptr [2];
  logic [3:0] mp  [2];
  int        tdur [2][4] = '{'{8, 3, 2, 6}, '{1, 1, 2, 6}};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ph[m]   = 0;
      left[m] = tdur[m][0];
      mptr[m] = 3;
      mp[m]   = '0;
    end
  endtask

  task automatic model_step(input int m, input logic [3:0] b);
    logic [3:0] set;
    logic [3:0] clr;
    int         g;
    bit         hit;
    set = b;
    clr = '0;
    if (ph[m] == 3 || ph[m] == 7) set[mptr[m]] = 1'b0;
    left[m]--;
    if (left[m] == 0) begin
      if ((ph[m] == 2 || ph[m] == 6) && mp[m] != 0) begin
        hit = 0;
        g   = 0;
        for (int k = 1; k <= 4; k++) begin
          if (!hit && mp[m][(mptr[m] + k) % 4]) begin
            hit = 1;
            g   = (mptr[m] + k) % 4;
          end
        end
        clr[g]  = 1'b1;
        mptr[m] = g;
        ph[m]   = ph[m] + 1;
      end else if (ph[m] == 2 || ph[m] == 6) begin
        ph[m] = (ph[m] + 2) % 8;
      end else begin
        ph[m] = (ph[m] + 1) % 8;
      end
      left[m] = tdur[m][ph[m] % 4];
    end
    mp[m] = (mp[m] | set) & ~clr;
  endtask

  function automatic logic [2:0] exp_a(input int m);
    return (ph[m] == 0) ? 3'b001 : (ph[m] == 1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] exp_b(input int m);
    return (ph[m] == 4) ? 3'b001 : (ph[m] == 5) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [3:0] exp_p(input int m);
    logic [3:0] v;
    v = '0;
    if (ph[m] == 3 || ph[m] == 7) v[mptr[m]] = 1'b1;
    return v;
  endfunction

  task automatic compare_all();
    chk("d0_A", 32'(bus0.A), 32'(exp_a(0)));
    chk("d0_B", 32'(bus0.B), 32'(exp_b(0)));
    chk("d0_P", 32'(bus0.P), 32'(exp_p(0)));
    chk("d0_pend", 32'(bus0.pend), 32'(mp[0]));
    chk("d1_A", 32'(bus1.A), 32'(exp_a(1)));
    chk("d1_B", 32'(bus1.B), 32'(exp_b(1)));
    chk("d1_P", 32'(bus1.P), 32'(exp_p(1)));
    chk("d1_pend", 32'(bus1.pend), 32'(mp[1]));
  endtask

  // Called away from edges; returns at posedge+3
  task automatic tick(input logic [3:0] b);
    bus0.bt = b;
    bus1.bt = b;
    @(posedge clk);
    if (rst) begin
      model_step(0, b);
      model_step(1, b);
    end else begin
      model_reset();
    end
    #1;
    compare_all();
    #2;
  endtask

  task automatic check_reset_consts();
    chk("rst_A", 32'(bus0.A), 32'h1);
    chk("rst_B", 32'(bus0.B), 32'h4);
    chk("rst_P", 32'(bus0.P), 32'h0);
    chk("rst_pend", 32'(bus0.pend), 32'h0);
    chk("rst_A1", 32'(bus1.A), 32'h1);
    chk("rst_pend1", 32'(bus1.pend), 32'h0);
  endtask

  // Leaves cycle 0 active at posedge+3 with rst released
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_consts();
    tick(4'b0000);
    rst = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    bus0.bt = '0;
    bus1.bt = '0;
    model_reset();
    #3;
    check_reset_consts();
    @(posedge clk);
    #3;
    rst = 1'b1;

    // Idle: two full periods, compare A green at period boundary
    for (int c = 0; c < 52; c++) tick(4'b0000);
    chk("period_A", 32'(bus0.A), 32'h1);

    // Single press at cycle 4
    do_reset();
    for (int c = 0; c < 19; c++) begin
      tick((c == 4) ? 4'b0100 : 4'b0000);
      if (c + 1 == 5)  chk("pend_lat", 32'(bus0.pend), 32'h4);
      if (c + 1 == 13) chk("ped_a_P", 32'(bus0.P), 32'h4);
      if (c + 1 == 13) chk("ped_a_pend", 32'(bus0.pend), 32'h0);
      if (c + 1 == 19) chk("b_green", 32'(bus0.B), 32'h1);
    end

    // Two presses together: index 0 first, index 3 next gap
    do_reset();
    for (int c = 0; c < 32; c++) begin
      tick((c == 0) ? 4'b1001 : 4'b0000);
      if (c + 1 == 13) chk("rr_first", 32'(bus0.P), 32'h1);
      if (c + 1 == 13) chk("rr_left", 32'(bus0.pend), 32'h8);
      if (c + 1 == 32) chk("rr_second", 32'(bus0.P), 32'h8);
    end

    // bt[1] held through its own walk phase
    do_reset();
    for (int c = 0; c < 32; c++) begin
      tick((c <= 19) ? 4'b0010 : 4'b0000);
      if (c + 1 == 13) chk("hold_gnt", 32'(bus0.P), 32'h2);
      if (c + 1 == 15) chk("hold_ign", 32'(bus0.pend), 32'h0);
      if (c + 1 == 20) chk("hold_relat", 32'(bus0.pend), 32'h2);
      if (c + 1 == 32) chk("hold_regnt", 32'(bus0.P), 32'h2);
    end

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 5) == 0) tick(4'($urandom));
      else tick(4'b0000);
    end

    // Async reset in the middle of a walk phase
    begin
      int budget;
      budget = 0;
      while (ph[0] != 3 && budget < 80) begin
        tick(4'b0001);
        budget++;
      end
      if (ph[0] != 3) chk("ped_wait", 32'h0, 32'h1);
      tick(4'b0000);
      rst = 1'b0;
      #1;
      model_reset();
      check_reset_consts();
      tick(4'b0000);
      rst = 1'b1;
      for (int c = 0; c < 8; c++) tick(4'b0000);
      chk("post_rst_A", 32'(bus0.A), 32'h2);
    end

    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0) tick(4'($urandom));
      else tick(4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/semaforo_arbitro.md
# semaforo_arbitro

Phase scheduler for a two-road intersection with pedestrian crossings. It drives the A and B traffic-light groups through a fixed green/yellow/all-red cycle. It latches pedestrian button presses from N_BT crosswalks and grants one exclusive walk phase per all-red gap, chosen round-robin. It sits above the semaforo light outputs and replaces the single-button control with a multi-requester scheduler.

## Interface
- T_VERDE, 8'd8: green duration in cycles (1..255)
- T_AMARELO, 8'd3: yellow duration in cycles (1..255)
- T_VERMELHO, 8'd2: all-red gap duration in cycles (1..255)
- T_PEDESTRE, 8'd6: walk phase duration in cycles (1..255)
- N_BT, 4: number of pedestrian buttons (2..8)
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- bt  in  N_BT  pedestrian buttons, active-high, sampled each rising edge
- A  out  3  light A, one-hot: 3'b001 verde, 3'b010 amarelo, 3'b100 vermelho
- B  out  3  light B, same encoding
- P  out  N_BT  walk grant, one-hot or zero
- pend  out  N_BT  latched pending requests

## Operation
- States: A_VERDE, A_AMARELO, VERM_A, PED_A, B_VERDE, B_AMARELO, VERM_B, PED_B.
- Transition order:
  - A_VERDE → A_AMARELO → VERM_A.
  - VERM_A → PED_A if pend≠0 at the exit edge, else → B_VERDE. PED_A → B_VERDE.
  - B_VERDE → B_AMARELO → VERM_B.
  - VERM_B → PED_B if pend≠0, else → A_VERDE. PED_B → A_VERDE.
- Outputs are decoded from the state register only (Moore); no combinational path from bt.
  - A is verde or amarelo only in A_*; vermelho otherwise. B likewise.
  - In VERM_* and PED_*, A = B = 3'b100.
  - P equals the granted one-hot only in PED_*; 0 otherwise.
- Dwell counter: 8-bit, down-counting.
  - Loaded with T_x−1 on entry to state x; the state exits on the edge where the counter is 0.
  - Each state lasts exactly T_x cycles.
- Request latch:
  - pend[i] sets on any edge where bt[i]=1. Held buttons re-set every cycle.
  - On the VERM_*→PED_* edge, the granted index clears.
  - In PED_*, bt for the granted index is ignored; other indices still latch.
  - If set and clear for the same index coincide, clear wins.
- Arbitration:
  - Round-robin pointer ptr holds the last granted index.
  - The grant is the first pend bit scanning ptr+1, ptr+2, … wrapping mod N_BT.
  - ptr updates to the granted index on entry to PED_*.
  - Only one crosswalk is granted per gap.

## Timing
- Reset (rst=0), effective immediately and asynchronously:
  - state A_VERDE, counter T_VERDE−1
  - A=001, B=100, P=0, pend=0, ptr=N_BT−1 (index 0 has first priority)
- Reset mid-phase, including mid-PED: all outputs return to their reset values at once; pending requests are lost.
- Latency from bt edge to pend: 1 edge. Grant appears on the first VERM_* exit after the latch.
- A press on the exit edge of VERM_* is latched but not granted in that gap.
- Full cycle with no requests: 2·(T_VERDE+T_AMARELO+T_VERMELHO) cycles (26 at defaults).

## Structure
- Shared package semaforo_pkg:
  - state enum
  - color encodings VERDE=3'b001, AMARELO=3'b010, VERMELHO=3'b100
  - DUR_W=8
- Sub-module rr_arbiter (N_BT parameter):
  - inputs req, ptr
  - outputs gnt one-hot and gnt_idx
  - purely combinational
- The state machine, counter and request latch stay in the top module.

## Test plan
- No presses, defaults: A=001 for 8 cycles, 010 for 3, both 100 for 2; then B=001 for 8; period 26; P stays 0.
- bt=4'b0100 pulsed 1 cycle at cycle 4 → pend=0100 at edge 5. At cycle 13, PED_A begins: P=0100 for 6 cycles, pend=0. B=001 at cycle 19.
- bt=4'b1001 together → first gap grants P=0001 and pend=1000. Next gap (VERM_B) grants P=1000, ptr=3.
- bt[1] held high through PED_A granted to index 1 → pend[1] stays 0 during PED. It re-latches the cycle after PED_A ends and is granted in the VERM_B gap.
- rst asserted mid-PED_A, asynchronously between edges → A=001, B=100, P=0, pend=0 immediately. Cycle restarts with A green for T_VERDE cycles.
- T_VERDE=1, T_AMARELO=1 overrides → each state holds exactly 1 cycle; no counter underflow or skipped states.
